ahb_bus_arbiter: RTL



---
 rtl/ahb_bus_arbiter_if.sv | 30 +++
 rtl/ahb_bus_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/ahb_bus_arbiter_if.sv
// ahb_bus_arbiter_if
// Arbitration signal bundle between the two AHB masters' request side,
// the muxed bus control and the arbiter.
//   master modport : drives hbusreq/hlock per master and the muxed
//                    htrans/hburst/hready; observes grants and ownership.
//   slave  modport : the arbiter's view; consumes requests and bus control,
//                    drives hgrant_m1/hgrant_m2, hmaster and hmastlock.
interface ahb_bus_arbiter_if;
    logic       hbusreq_m1;
    logic       hbusreq_m2;
    logic       hlock_m1;
    logic       hlock_m2;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic       hready;
    logic       hgrant_m1;
    logic       hgrant_m2;
    logic [3:0] hmaster;
    logic       hmastlock;

    modport master (
        output hbusreq_m1, hbusreq_m2, hlock_m1, hlock_m2, htrans, hburst, hready,
        input  hgrant_m1, hgrant_m2, hmaster, hmastlock
    );

    modport slave (
        input  hbusreq_m1, hbusreq_m2, hlock_m1, hlock_m2, htrans, hburst, hready,
        output hgrant_m1, hgrant_m2, hmaster, hmastlock
    );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter
// Two-master AHB-Lite-style arbiter: master 1 (CPU) and master 2 (DMA).
// Master 1 is the default/parking master. Fixed-length bursts and locked
// sequences are never broken; undefined-length INCR may be re-arbitrated
// on any beat.
// Ports:
//   hclk   : bus clock, all state updates on the rising edge
//   hreset : synchronous, active-high reset
//   bus    : ahb_bus_arbiter_if.slave (requests, locks, htrans, hburst,
//            hready in; hgrant_m1, hgrant_m2, hmaster, hmastlock out)
// Build option:
//   AHB_ARB_RR_EN : round-robin on contention (master not last granted
//                   wins). Undefined: fixed priority, master 1 wins.
module ahb_bus_arbiter (
    input  logic             hclk,
    input  logic             hreset,
    ahb_bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        TR_IDLE   = 2'b00,
        TR_BUSY   = 2'b01,
        TR_NONSEQ = 2'b10,
        TR_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic {
        OWN_M1 = 1'b0,
        OWN_M2 = 1'b1
    } owner_t;

    owner_t     grant_q;
    owner_t     grant_d;
    logic       hgrant_m1_q;
    logic       hgrant_m2_q;
    logic [3:0] hmaster_q;
    logic       hmastlock_q;
    logic [3:0] rem;
    logic [3:0] burst_load;
    logic       granted_lock;
    logic       locked;
    logic       window;
    logic       nonseq_acc;
    logic       seq_acc;

`ifdef AHB_ARB_RR_EN
    owner_t     last_q;
`endif

    assign bus.hgrant_m1 = hgrant_m1_q;
    assign bus.hgrant_m2 = hgrant_m2_q;
    assign bus.hmaster   = hmaster_q;
    assign bus.hmastlock = hmastlock_q;

    always_comb begin
        nonseq_acc   = bus.hready && (bus.htrans == TR_NONSEQ);
        seq_acc      = bus.hready && (bus.htrans == TR_SEQ);
        granted_lock = (grant_q == OWN_M1) ? bus.hlock_m1 : bus.hlock_m2;
        locked       = granted_lock || hmastlock_q;
        // Last beat of a fixed burst is being accepted when rem==1 on SEQ,
        // so the next owner can be granted in parallel with it.
        window       = bus.hready && !locked &&
                       ((rem == 4'd0) || ((rem == 4'd1) && (bus.htrans == TR_SEQ)));

        case (bus.hburst)
            3'b010, 3'b011: burst_load = 4'd3;
            3'b100, 3'b101: burst_load = 4'd7;
            3'b110, 3'b111: burst_load = 4'd15;
            default:        burst_load = 4'd0;   // SINGLE, INCR
        endcase

        grant_d = grant_q;
        if (window) begin
            case ({bus.hbusreq_m1, bus.hbusreq_m2})
                2'b01:   grant_d = OWN_M2;
`ifdef AHB_ARB_RR_EN
                2'b11:   grant_d = (last_q == OWN_M1) ? OWN_M2 : OWN_M1;
`else
                2'b11:   grant_d = OWN_M1;
`endif
                default: grant_d = OWN_M1;       // m1 only, or park on m1
            endcase
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            grant_q     <= OWN_M1;
            hgrant_m1_q <= 1'b1;
            hgrant_m2_q <= 1'b0;
            hmaster_q   <= 4'd1;
            hmastlock_q <= 1'b0;
            rem         <= '0;
`ifdef AHB_ARB_RR_EN
            last_q      <= OWN_M1;
`endif
        end else begin
            grant_q     <= grant_d;
            hgrant_m1_q <= (grant_d == OWN_M1);
            hgrant_m2_q <= (grant_d == OWN_M2);
`ifdef AHB_ARB_RR_EN
            if (grant_d != grant_q) begin
                last_q <= grant_d;
            end
`endif
            if (nonseq_acc) begin
                rem <= burst_load;
            end else if (seq_acc && (rem != 4'd0)) begin
                rem <= rem - 4'd1;
            end

            // Address-phase ownership follows the grant that was in force
            // while the accepted address was driven.
            if (bus.hready) begin
                hmaster_q   <= (grant_q == OWN_M1) ? 4'd1 : 4'd2;
                hmastlock_q <= granted_lock;
            end
        end
    end

endmodule
